// File: rtl/inst_mem_loader.sv
// inst_mem_loader: boot loader that streams a counted, big-endian word image into
// instruction memory and holds the processor until the final word is committed.
module inst_mem_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  start,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  overflow,
    output logic [15:0]           words_loaded
);
    localparam logic [16:0] DEPTH = 17'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {HDR_HI, HDR_LO, DATA, FLUSH, DONE} state_t;

    state_t      state;
    logic [1:0]  lane;
    logic [15:0] idx;
    logic [15:0] count;
    logic [23:0] shift;
    logic        accept;

    assign in_ready = (state == HDR_HI) || (state == HDR_LO) || (state == DATA);
    assign cpu_hold = state != DONE;
    assign done     = state == DONE;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= HDR_HI;
            lane         <= 2'd0;
            idx          <= 16'd0;
            count        <= 16'd0;
            shift        <= 24'd0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            overflow     <= 1'b0;
            words_loaded <= 16'd0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                HDR_HI: if (accept) begin
                    count[15:8] <= in_data;
                    state       <= HDR_LO;
                end
                HDR_LO: if (accept) begin
                    count[7:0] <= in_data;
                    overflow   <= {1'b0, count[15:8], in_data} > DEPTH;
                    state      <= ({count[15:8], in_data} == 16'd0) ? DONE : DATA;
                end
                DATA: if (accept) begin
                    lane  <= lane + 2'd1;
                    shift <= {shift[15:0], in_data};
                    if (lane == 2'd3) begin
                        // words past the memory end are consumed but never written
                        if ({1'b0, idx} < DEPTH) begin
                            mem_we       <= 1'b1;
                            mem_addr     <= idx[ADDR_WIDTH-1:0];
                            mem_wdata    <= {shift, in_data};
                            words_loaded <= words_loaded + 16'd1;
                        end
                        idx <= idx + 16'd1;
                        if (idx == count - 16'd1)
                            state <= FLUSH;
                    end
                end
                FLUSH: state <= DONE;
                DONE: if (start) begin
                    state        <= HDR_HI;
                    lane         <= 2'd0;
                    idx          <= 16'd0;
                    overflow     <= 1'b0;
                    words_loaded <= 16'd0;
                end
                default: state <= HDR_HI;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_mem_loader.sv
// tb_inst_mem_loader: scoreboard bench; expected writes are queued as words are sent
// and popped when the loader strobes mem_we.
module tb_inst_mem_loader;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        start = 1'b0;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        overflow;
    logic [15:0] words_loaded;

    int checks = 0;
    int errors = 0;
    int writes = 0;
    logic [41:0] sb[$];
    logic [31:0] prog [3] = '{32'h20080005, 32'h2009000A, 32'h01095020};

    inst_mem_loader #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
        .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .start(start), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .done(done), .overflow(overflow),
        .words_loaded(words_loaded)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset_n && mem_we) begin
            writes++;
            if (sb.size() == 0)
                check("spurious_we", 32'd1, 32'd0);
            else begin
                logic [41:0] e;
                e = sb.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e[41:32]));
                check("wr_data", mem_wdata, e[31:0]);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        if (!in_ready) begin
            check("in_ready_when_sending", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            tick(1);
            in_valid = 1'b0;
        end
    endtask

    task automatic send_hdr(input logic [15:0] n);
        send_byte(n[15:8]);
        send_byte(n[7:0]);
    endtask

    // gap: 0 none, 1 random idles, 2 random idles plus 5 idles before the last byte
    task automatic send_word(input logic [31:0] w, input int i, input int gap);
        for (int b = 0; b < 4; b++) begin
            if (gap != 0) tick($urandom_range(0, 2));
            if (gap == 2 && b == 3) tick(5);
            send_byte(w[31-8*b -: 8]);
        end
        if (i < 1024) sb.push_back({10'(i), w});
    endtask

    task automatic expect_finish(input logic [15:0] wl);
        check("flush_in_ready", 32'(in_ready), 32'd0);
        check("flush_hold", 32'(cpu_hold), 32'd1);
        check("flush_done", 32'(done), 32'd0);
        tick(1);
        check("done", 32'(done), 32'd1);
        check("cpu_hold_released", 32'(cpu_hold), 32'd0);
        check("words_loaded", 32'(words_loaded), 32'(wl));
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("start_hold", 32'(cpu_hold), 32'd1);
        check("start_done", 32'(done), 32'd0);
        check("start_wl", 32'(words_loaded), 32'd0);
        check("start_overflow", 32'(overflow), 32'd0);
        check("start_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_hold"}, 32'(cpu_hold), 32'd1);
        check({tag, "_we"}, 32'(mem_we), 32'd0);
        check({tag, "_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_wdata"}, mem_wdata, 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
        check({tag, "_wl"}, 32'(words_loaded), 32'd0);
    endtask

    initial begin
        #12;
        check_reset_vals("rst");
        reset_n = 1'b1;
        tick(1);
        check_reset_vals("post_rst");

        // 3-word program at one byte per cycle
        writes = 0;
        send_hdr(16'd3);
        for (int i = 0; i < 3; i++) send_word(prog[i], i, 0);
        expect_finish(16'd3);
        check("prog_writes", 32'(writes), 32'd3);

        // zero count: done on the second header byte
        pulse_start();
        writes = 0;
        send_hdr(16'd0);
        check("zero_done", 32'(done), 32'd1);
        check("zero_wl", 32'(words_loaded), 32'd0);
        check("zero_in_ready", 32'(in_ready), 32'd0);
        in_data  = 8'h55;
        in_valid = 1'b1;
        tick(3);
        in_valid = 1'b0;
        check("zero_in_ready_held", 32'(in_ready), 32'd0);
        check("zero_still_done", 32'(done), 32'd1);
        check("zero_writes", 32'(writes), 32'd0);

        // reload with a start pulse in DATA that must be ignored
        pulse_start();
        writes = 0;
        send_hdr(16'd1);
        send_byte(8'hDE);
        send_byte(8'hAD);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("start_in_data_hold", 32'(cpu_hold), 32'd1);
        check("start_in_data_ready", 32'(in_ready), 32'd1);
        send_byte(8'hBE);
        send_byte(8'hEF);
        sb.push_back({10'd0, 32'hDEADBEEF});
        expect_finish(16'd1);
        check("reload_writes", 32'(writes), 32'd1);

        // valid gaps, including 5 idles before the last byte of word 0
        pulse_start();
        writes = 0;
        send_hdr(16'd2);
        send_word(32'hCAFEF00D, 0, 2);
        send_word(32'h12345678, 1, 1);
        expect_finish(16'd2);
        check("gap_writes", 32'(writes), 32'd2);

        // reset after two bytes of word 1, then a fresh load
        pulse_start();
        send_hdr(16'd3);
        send_word(32'hA5A5A5A5, 0, 0);
        send_byte(8'h11);
        send_byte(8'h22);
        #2 reset_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        #3 reset_n = 1'b1;
        tick(1);
        check("sb_after_reset", 32'(sb.size()), 32'd0);
        writes = 0;
        send_hdr(16'd3);
        for (int i = 0; i < 3; i++) send_word(32'h0BAD0000 + 32'(i), i, 0);
        expect_finish(16'd3);
        check("fresh_writes", 32'(writes), 32'd3);

        // overflow: 1030 words into a 1024-word memory
        pulse_start();
        writes = 0;
        send_hdr(16'd1030);
        check("overflow_set", 32'(overflow), 32'd1);
        for (int i = 0; i < 1030; i++) send_word({16'(i), ~16'(i)}, i, 0);
        expect_finish(16'd1024);
        check("ovf_writes", 32'(writes), 32'd1024);
        check("overflow_kept", 32'(overflow), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
